stream_mux_rr: RTL and testbench
================================

# stream_mux_rr

Parametrised N-channel streaming multiplexer with a valid/ready handshake on every input and on the output. It selects one channel per cycle, either by an external select (manual mode) or by a fair round-robin arbiter (RR mode). The result goes into a single registered output slot tagged with the source channel. It replaces the combinational 4-to-1 select wherever channels carry flow-controlled data into a shared downstream consumer.

## Interface
- N, default 4: number of input channels (2..16).
- W, default 8: data width per channel.
- SW: derived, not overridable; equals clog2(N), minimum 1.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous reset, active low.
- mode  in  1  0 = manual select, 1 = round-robin.
- sel  in  SW  channel index used in manual mode.
- in_data  in  N*W  channel i occupies bits [i*W +: W].
- in_valid  in  N  per-channel valid.
- in_ready  out  N  per-channel ready (combinational).
- out_data  out  W  registered output data.
- out_chan  out  SW  index of the channel that produced out_data.
- out_valid  out  1  output slot holds data.
- out_ready  in  1  downstream accepts out_data this cycle.

## Operation
- Single output slot {out_data, out_chan, out_valid}.
- load_en = !out_valid || out_ready. The slot can accept new data this cycle.
- Grant selection (combinational, one channel at most):
  - Manual mode:
    - If sel >= N: no grant.
    - Else if in_valid[sel]: grant = sel.
    - Else: no grant.
  - RR mode:
    - Scan channels ptr, ptr+1, …, N-1, 0, …, ptr-1.
    - Grant the first channel whose in_valid is 1.
- in_ready[i] = rst_n && load_en && grant exists && grant == i. At most one bit of in_ready is high.
- A transfer on channel g occurs when in_valid[g] && in_ready[g]. On that edge:
  - out_data <= in_data[g].
  - out_chan <= g.
  - out_valid <= 1.
- If load_en is 1 and there is no grant: out_valid <= 0. out_data and out_chan keep their values.
- If out_valid && !out_ready: the slot holds. out_data and out_chan stay stable. All in_ready bits are 0.
- Round-robin pointer ptr (SW bits):
  - After an RR-mode transfer from channel g: ptr <= (g+1) mod N. Wrap from N-1 to 0.
  - Manual-mode transfers do not change ptr.
- Mode and sel are sampled combinationally each cycle. A change takes effect on the next grant decision and never alters data already in the slot.
- The block does not buffer, reorder or drop data. Data not granted stays upstream, because its in_ready is low.

## Timing
- Reset (rst_n low, asynchronous):
  - out_valid = 0, out_data = 0, out_chan = 0, ptr = 0.
  - in_ready = all zeros while rst_n is low.
- Latency: input transfer at edge k gives out_valid = 1 with that data after edge k (visible in cycle k+1).
- Throughput: one transfer per cycle while out_ready is held high and a grant exists.
- Simultaneous consume and load: out_valid=1, out_ready=1 and a grant exist in the same cycle. The old word is consumed and the new word loads on the same edge, with no bubble.
- Combinational paths: out_ready, in_valid, mode and sel feed in_ready in the same cycle. There is no path from in_* to out_* other than through registers.
- Reset asserted mid-transfer: slot contents are lost and ptr returns to 0. Upstream sees in_ready = 0 immediately.
- Release of rst_n is synchronised externally. The first grant is evaluated in the first cycle after release.

## Test plan
- Reset: hold rst_n=0 with all in_valid=1111 and out_ready=1 → in_ready=0000, out_valid=0, out_data=0x00, out_chan=0. Release rst_n → transfers start in the next cycle.
- Manual mode, N=4, W=8, in_data={0x44,0x33,0x22,0x11}, all in_valid=1, out_ready=1, sel stepping 1,3,2,0 once per cycle → out_data 0x22,0x44,0x33,0x11 with out_chan 1,3,2,0, each one cycle after its sel. With sel=2 and in_valid[2]=0 → in_ready=0000 and out_valid drops to 0.
- RR fairness: mode=1, all in_valid=1, out_ready=1 for 8 cycles → out_chan sequence 0,1,2,3,0,1,2,3. With only channels 1 and 3 valid → 1,3,1,3.
- Backpressure: out_valid=1 holding 0x33, out_ready=0 for 5 cycles with all inputs valid → out_data stays 0x33, in_ready=0000, ptr unchanged. On out_ready=1 → the next channel in RR order loads on the same edge.
- Mode switch: RR mode with ptr=2, switch to manual with sel=0 for 3 transfers, then back to RR → the next RR grant is channel 2 (ptr was not moved by manual transfers). A sel value of 3 with N=3 is out of range → no grant.
- Reset mid-stream: assert rst_n for 1 cycle while out_valid=1 and ptr=3 → out_valid=0 and ptr=0 immediately. The first RR grant after release is channel 0.

Source files
------------

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with manual or round-robin channel
// selection, feeding a single registered output slot tagged with its source.
module stream_mux_rr #(
   parameter  int N  = 4,
   parameter  int W  = 8,
   localparam int SW = (N <= 2) ? 1 : $clog2(N)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           i_mode,
   input  logic [SW-1:0]  i_sel,
   input  logic [N*W-1:0] i_in_data,
   input  logic [N-1:0]   i_in_valid,
   output logic [N-1:0]   o_in_ready,
   output logic [W-1:0]   o_out_data,
   output logic [SW-1:0]  o_out_chan,
   output logic           o_out_valid,
   input  logic           i_out_ready
);

   logic [SW-1:0] r_ptr;
   logic [W-1:0]  r_data;
   logic [SW-1:0] r_chan;
   logic          r_valid;

   logic          w_loadEn;
   logic          w_manFound;
   logic [SW-1:0] w_manIdx;
   logic          w_rrFound;
   logic [SW-1:0] w_rrIdx;
   logic          w_grantValid;
   logic [SW-1:0] w_grantIdx;
   logic [W-1:0]  w_grantData;
   logic [SW-1:0] w_ptrNext;

   assign w_loadEn = !r_valid || i_out_ready;

   // Out-of-range select values match no channel, so they never grant.
   always_comb begin
      w_manFound = 1'b0;
      w_manIdx   = '0;
      for (int i = 0; i < N; i++) begin
         if (i_sel == SW'(i) && i_in_valid[i]) begin
            w_manFound = 1'b1;
            w_manIdx   = SW'(i);
         end
      end
   end

   always_comb begin
      w_rrFound = 1'b0;
      w_rrIdx   = '0;
      for (int k = 0; k < N; k++) begin
         if (!w_rrFound && i_in_valid[(int'(r_ptr) + k) % N]) begin
            w_rrFound = 1'b1;
            w_rrIdx   = SW'((int'(r_ptr) + k) % N);
         end
      end
   end

   assign w_grantValid = i_mode ? w_rrFound : w_manFound;
   assign w_grantIdx   = i_mode ? w_rrIdx   : w_manIdx;
   assign w_ptrNext    = (w_grantIdx == SW'(N - 1)) ? '0 : w_grantIdx + 1'b1;

   always_comb begin
      w_grantData = '0;
      o_in_ready  = '0;
      for (int i = 0; i < N; i++) begin
         if (w_grantIdx == SW'(i)) begin
            w_grantData = i_in_data[i*W +: W];
         end
         o_in_ready[i] = rst_n && w_loadEn && w_grantValid && (w_grantIdx == SW'(i));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr   <= '0;
         r_data  <= '0;
         r_chan  <= '0;
         r_valid <= 1'b0;
      end else if (w_loadEn) begin
         if (w_grantValid) begin
            r_data  <= w_grantData;
            r_chan  <= w_grantIdx;
            r_valid <= 1'b1;
            if (i_mode) begin
               r_ptr <= w_ptrNext;
            end
         end else begin
            r_valid <= 1'b0;
         end
      end
   end

   assign o_out_data  = r_data;
   assign o_out_chan  = r_chan;
   assign o_out_valid = r_valid;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: directed literal sequences plus randomized traffic,
// all cycles compared against a queue-free behavioural model of the slot.
module tb_stream_mux_rr;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int SW = 2;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           i_mode;
   logic [SW-1:0]  i_sel;
   logic [N*W-1:0] i_in_data;
   logic [N-1:0]   i_in_valid;
   logic [N-1:0]   o_in_ready;
   logic [W-1:0]   o_out_data;
   logic [SW-1:0]  o_out_chan;
   logic           o_out_valid;
   logic           i_out_ready;

   logic [1:0]     i3_sel;
   logic [2:0]     o3_in_ready;
   logic [W-1:0]   o3_out_data;
   logic [1:0]     o3_out_chan;
   logic           o3_out_valid;

   int checks = 0;
   int errors = 0;

   stream_mux_rr #(.N(N), .W(W)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_mode      (i_mode),
      .i_sel       (i_sel),
      .i_in_data   (i_in_data),
      .i_in_valid  (i_in_valid),
      .o_in_ready  (o_in_ready),
      .o_out_data  (o_out_data),
      .o_out_chan  (o_out_chan),
      .o_out_valid (o_out_valid),
      .i_out_ready (i_out_ready)
   );

   // Three-channel instance exercises a select value that names no channel.
   stream_mux_rr #(.N(3), .W(W)) u_dut3 (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_mode      (1'b0),
      .i_sel       (i3_sel),
      .i_in_data   (24'h332211),
      .i_in_valid  (3'b111),
      .o_in_ready  (o3_in_ready),
      .o_out_data  (o3_out_data),
      .o_out_chan  (o3_out_chan),
      .o_out_valid (o3_out_valid),
      .i_out_ready (1'b1)
   );

   always #5 clk = ~clk;

   task automatic checkVal(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic m, input logic [SW-1:0] s,
                                input logic [N-1:0] v, input logic r);
      @(posedge clk);
      #1;
      rst_n       = rst;
      i_mode      = m;
      i_sel       = s;
      i_in_valid  = v;
      i_out_ready = r;
   endtask

   task automatic checkOutput(input string name, input logic expValid, input logic [W-1:0] expData,
                              input logic [SW-1:0] expChan, input logic [N-1:0] expReady);
      @(negedge clk);
      checkVal({name, ".valid"}, 32'(o_out_valid), 32'(expValid));
      checkVal({name, ".data"},  32'(o_out_data),  32'(expData));
      checkVal({name, ".chan"},  32'(o_out_chan),  32'(expChan));
      checkVal({name, ".ready"}, 32'(o_in_ready),  32'(expReady));
   endtask

   // Behavioural model: one slot plus a rotating start index.
   logic         mValid;
   logic [W-1:0] mData;
   int           mChan;
   int           mPtr;

   function automatic int modelGrant();
      if (!i_mode) begin
         return (int'(i_sel) < N && i_in_valid[i_sel]) ? int'(i_sel) : -1;
      end
      for (int k = 0; k < N; k++) begin
         if (i_in_valid[(mPtr + k) % N]) return (mPtr + k) % N;
      end
      return -1;
   endfunction

   initial begin
      int           g;
      logic         loadEn;
      logic [N-1:0] expReady;
      mValid = 1'b0;
      mData  = '0;
      mChan  = 0;
      mPtr   = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            mValid = 1'b0;
            mData  = '0;
            mChan  = 0;
            mPtr   = 0;
         end
         g        = modelGrant();
         loadEn   = !mValid || i_out_ready;
         expReady = (rst_n && loadEn && g >= 0) ? N'(1 << g) : '0;
         checkVal("model.valid", 32'(o_out_valid), 32'(mValid));
         checkVal("model.data",  32'(o_out_data),  32'(mData));
         checkVal("model.chan",  32'(o_out_chan),  32'(mChan));
         checkVal("model.ready", 32'(o_in_ready),  32'(expReady));
         @(posedge clk);
         if (rst_n && loadEn) begin
            if (g >= 0) begin
               mData  = i_in_data[g*W +: W];
               mChan  = g;
               mValid = 1'b1;
               if (i_mode) mPtr = (g + 1) % N;
            end else begin
               mValid = 1'b0;
            end
         end
      end
   end

   localparam logic [N-1:0] ALL = 4'b1111;

   initial begin
      rst_n       = 1'b0;
      i_mode      = 1'b0;
      i_sel       = '0;
      i_in_data   = 32'h44332211;
      i_in_valid  = ALL;
      i_out_ready = 1'b1;
      i3_sel      = 2'd3;

      repeat (2) @(posedge clk);
      checkOutput("reset", 1'b0, 8'h00, 2'd0, 4'b0000);

      applyStimulus(1, 0, 2'd1, ALL, 1);     checkOutput("man_sel1",  0, 8'h00, 2'd0, 4'b0010);
      applyStimulus(1, 0, 2'd3, ALL, 1);     checkOutput("man_sel3",  1, 8'h22, 2'd1, 4'b1000);
      applyStimulus(1, 0, 2'd2, ALL, 1);     checkOutput("man_sel2",  1, 8'h44, 2'd3, 4'b0100);
      applyStimulus(1, 0, 2'd0, ALL, 1);     checkOutput("man_sel0",  1, 8'h33, 2'd2, 4'b0001);
      applyStimulus(1, 0, 2'd2, 4'b1011, 1); checkOutput("man_noval", 1, 8'h11, 2'd0, 4'b0000);
      applyStimulus(1, 0, 2'd2, 4'b1011, 1); checkOutput("man_drop",  0, 8'h11, 2'd0, 4'b0000);

      applyStimulus(1, 1, 2'd0, ALL, 1);     checkOutput("rr_start",  0, 8'h11, 2'd0, 4'b0001);
      for (int k = 0; k < 8; k++) begin
         applyStimulus(1, 1, 2'd0, ALL, 1);
         checkOutput("rr_all", 1, W'(8'h11 * (k % 4 + 1)), SW'(k % 4), N'(1 << ((k + 1) % 4)));
      end
      for (int k = 0; k < 5; k++) begin
         int c;
         c = (k == 0) ? 0 : ((k % 2 == 1) ? 1 : 3);
         applyStimulus(1, 1, 2'd0, 4'b1010, 1);
         checkOutput("rr_odd", 1, W'(8'h11 * (c + 1)), SW'(c), (k % 2 == 0) ? 4'b0010 : 4'b1000);
      end

      applyStimulus(1, 1, 2'd0, ALL, 1);     checkOutput("bp_load",   1, 8'h22, 2'd1, 4'b0100);
      repeat (5) begin
         applyStimulus(1, 1, 2'd0, ALL, 0);  checkOutput("bp_hold",   1, 8'h33, 2'd2, 4'b0000);
      end
      applyStimulus(1, 1, 2'd0, ALL, 1);     checkOutput("bp_release", 1, 8'h33, 2'd2, 4'b1000);
      applyStimulus(1, 1, 2'd0, ALL, 1);     checkOutput("rr_after_bp", 1, 8'h44, 2'd3, 4'b0001);
      applyStimulus(1, 1, 2'd0, ALL, 1);     checkOutput("rr_ptr2",   1, 8'h11, 2'd0, 4'b0010);

      applyStimulus(1, 0, 2'd0, ALL, 1);     checkOutput("sw_man0",   1, 8'h22, 2'd1, 4'b0001);
      applyStimulus(1, 0, 2'd0, ALL, 1);     checkOutput("sw_man1",   1, 8'h11, 2'd0, 4'b0001);
      applyStimulus(1, 0, 2'd0, ALL, 1);     checkOutput("sw_man2",   1, 8'h11, 2'd0, 4'b0001);
      applyStimulus(1, 1, 2'd0, ALL, 1);     checkOutput("sw_back_rr", 1, 8'h11, 2'd0, 4'b0100);

      applyStimulus(1, 1, 2'd0, ALL, 0);     checkOutput("pre_reset", 1, 8'h33, 2'd2, 4'b0000);
      applyStimulus(0, 1, 2'd0, ALL, 1);     checkOutput("mid_reset", 0, 8'h00, 2'd0, 4'b0000);
      applyStimulus(1, 1, 2'd0, ALL, 1);     checkOutput("post_reset", 0, 8'h00, 2'd0, 4'b0001);
      applyStimulus(1, 1, 2'd0, ALL, 1);     checkOutput("post_reset_ch0", 1, 8'h11, 2'd0, 4'b0010);

      @(negedge clk);
      checkVal("n3_sel3.ready", 32'(o3_in_ready), 32'h0);
      checkVal("n3_sel3.valid", 32'(o3_out_valid), 32'h0);
      @(posedge clk); #1; i3_sel = 2'd2;
      @(negedge clk);
      checkVal("n3_sel2.ready", 32'(o3_in_ready), 32'h4);
      @(posedge clk); #1; i3_sel = 2'd3;
      @(negedge clk);
      checkVal("n3_load.valid", 32'(o3_out_valid), 32'h1);
      checkVal("n3_load.data",  32'(o3_out_data),  32'h33);
      checkVal("n3_load.chan",  32'(o3_out_chan),  32'h2);
      checkVal("n3_back.ready", 32'(o3_in_ready),  32'h0);
      @(negedge clk);
      checkVal("n3_drop.valid", 32'(o3_out_valid), 32'h0);

      for (int n = 0; n < 3000; n++) begin
         @(posedge clk);
         #1;
         rst_n       = ($urandom_range(0, 199) != 0);
         if ($urandom_range(0, 7) == 0) i_mode = $urandom_range(0, 1) != 0;
         i_sel       = SW'($urandom_range(0, N - 1));
         i_in_valid  = N'($urandom);
         i_out_ready = ($urandom_range(0, 3) != 0);
         i_in_data   = $urandom;
      end

      @(posedge clk);
      #2;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
